// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check master.
//   TIMER_W / DATA_W : per-transaction timer width and Avalon data width
//   ADDR_ID / ADDR_TS: word addresses of the ID and timestamp registers
//   state_e          : sequencing FSM of the top level
//   phase_e          : phase of a single Avalon read
package sysid_check_pkg;

  localparam int unsigned TIMER_W = 16;
  localparam int unsigned DATA_W  = 32;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_WT_ID = 3'd2,
    ST_RD_TS = 3'd3,
    ST_WT_TS = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_REQ  = 2'd1,
    PH_WAIT = 2'd2
  } phase_e;

endpackage

// File: rtl/avm_single_read.sv
// One Avalon-MM read with waitrequest, readdatavalid and a per-read timeout.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   launch_i, addr_i     : start a read of word addr_i on the next cycle
//   avm_read_o/address_o : registered Avalon request
//   avm_waitrequest_i,
//   avm_readdatavalid_i  : Avalon response qualifiers
//   accept_c_o           : request accepted this cycle (combinational)
//   capture_c_o          : read data valid for this read this cycle (combinational)
//   timeout_c_o          : read gives up this cycle (combinational)
module avm_single_read
  import sysid_check_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic launch_i,
  input  logic addr_i,
  output logic avm_read_o,
  output logic avm_address_o,
  input  logic avm_waitrequest_i,
  input  logic avm_readdatavalid_i,
  output logic accept_c_o,
  output logic capture_c_o,
  output logic timeout_c_o
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  phase_e             phase_q;
  logic               read_q;
  logic               addr_q;
  logic [TIMER_W-1:0] timer_q;

  assign avm_read_o    = read_q;
  assign avm_address_o = addr_q;

  // readdatavalid only counts once the request is accepted (same cycle for latency-0)
  assign accept_c_o  = (phase_q == PH_REQ) && read_q && !avm_waitrequest_i;
  assign capture_c_o = (accept_c_o || (phase_q == PH_WAIT)) && avm_readdatavalid_i;
  // a capture on the last allowed cycle wins over the timeout
  assign timeout_c_o = (phase_q != PH_IDLE) && (timer_q == TIMER_LAST) && !capture_c_o;

  // Request/phase/timer registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      phase_q <= PH_IDLE;
      read_q  <= 1'b0;
      addr_q  <= ADDR_ID;
      timer_q <= '0;
    end else if (launch_i) begin
      phase_q <= PH_REQ;
      read_q  <= 1'b1;
      addr_q  <= addr_i;
      timer_q <= '0;
    end else if (capture_c_o || timeout_c_o) begin
      // timeout may drop read while stalled; the abort is intentional
      phase_q <= PH_IDLE;
      read_q  <= 1'b0;
    end else begin
      if (accept_c_o) begin
        phase_q <= PH_WAIT;
        read_q  <= 1'b0;
      end
      if (phase_q != PH_IDLE) begin
        timer_q <= timer_q + TIMER_W'(1);
      end
    end
  end

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read-only master that reads the system-ID slave (word 0 = ID,
// word 1 = timestamp), compares both to expected values and reports
// pass/fail/timeout. Gates downstream bring-up until identity is confirmed.
//   clock, reset_n     : clock, synchronous active-low reset
//   start              : one-cycle check request, ignored while busy
//   avm_*              : Avalon-MM read master port
//   busy, done         : check in progress / finished (held until next start)
//   id_ok, ts_ok       : comparison results, valid when done
//   timeout            : a read exceeded TIMEOUT_CYCLES
//   id_value, ts_value : captured words
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1457589968,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value
);

  state_e state_q;
  logic   pending_q;
  logic   in_id_c;
  logic   in_ts_c;
  logic   launch_c;
  logic   rd_addr_c;
  logic   accept_c;
  logic   capture_c;
  logic   timeout_c;

  assign in_id_c = (state_q == ST_RD_ID) || (state_q == ST_WT_ID);
  assign in_ts_c = (state_q == ST_RD_TS) || (state_q == ST_WT_TS);

  // A new read starts on check launch, and again right after the ID capture
  assign launch_c = (((state_q == ST_IDLE) || (state_q == ST_DONE)) && (start || pending_q))
                  || (in_id_c && capture_c);
  assign rd_addr_c = in_id_c ? ADDR_TS : ADDR_ID;

  avm_single_read #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd (
    .clk_i               (clock),
    .rst_ni              (reset_n),
    .launch_i            (launch_c),
    .addr_i              (rd_addr_c),
    .avm_read_o          (avm_read),
    .avm_address_o       (avm_address),
    .avm_waitrequest_i   (avm_waitrequest),
    .avm_readdatavalid_i (avm_readdatavalid),
    .accept_c_o          (accept_c),
    .capture_c_o         (capture_c),
    .timeout_c_o         (timeout_c)
  );

  // Check sequencer with registered status outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= AUTO_START;
      busy      <= 1'b0;
      done      <= 1'b0;
      id_ok     <= 1'b0;
      ts_ok     <= 1'b0;
      timeout   <= 1'b0;
      id_value  <= '0;
      ts_value  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (launch_c) begin
            state_q   <= ST_RD_ID;
            pending_q <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        ST_RD_ID, ST_WT_ID: begin
          if (capture_c) begin
            id_value <= avm_readdata;
            id_ok    <= (avm_readdata == EXPECTED_ID);
            state_q  <= ST_RD_TS;
          end else if (timeout_c) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (accept_c) begin
            state_q <= ST_WT_ID;
          end
        end
        ST_RD_TS, ST_WT_TS: begin
          if (capture_c) begin
            ts_value <= avm_readdata;
            ts_ok    <= (avm_readdata == EXPECTED_TS);
            state_q  <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (timeout_c) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (accept_c) begin
            state_q <= ST_WT_TS;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // in_ts_c documents the timestamp half of the sequence for readers/debug
  logic unused_c;
  assign unused_c = in_ts_c;

endmodule
